// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline flow controller.
package pipe_ctrl_pkg;

  localparam int unsigned STG_IF  = 0;
  localparam int unsigned STG_ID  = 1;
  localparam int unsigned STG_EXE = 2;
  localparam int unsigned STG_MEM = 3;
  localparam int unsigned STG_WB  = 4;

  // Widest pipeline supported; the top trims commands to NUM_PREGS.
  localparam int unsigned PREG_MAX = 8;

  typedef enum logic {
    RUN  = 1'b0,
    BUSY = 1'b1
  } mc_state_e;

  typedef struct packed {
    logic                pc_en;
    logic [PREG_MAX-1:0] en;
    logic [PREG_MAX-1:0] clr;
  } flow_cmd_t;

  // Mask with the n lowest register bits set (registers 0..n-1).
  function automatic logic [PREG_MAX-1:0] low_mask(input int unsigned n);
    return PREG_MAX'((64'd1 << n) - 64'd1);
  endfunction

endpackage

// File: rtl/mc_tracker.sv
// Multi-cycle op occupancy tracker: RUN/BUSY FSM with a down-counter
// that keeps EXE occupied for LATENCY cycles in total.
module mc_tracker
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned LATENCY = 34
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic kill,
  input  logic hold,
  output logic busy,
  output logic releasing
);

  localparam int unsigned CW    = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
  localparam logic        MULTI = 1'(LATENCY > 1);
  localparam logic [CW-1:0] LOAD = CW'((LATENCY > 1) ? LATENCY - 2 : 0);

  mc_state_e     state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // The counter runs through external stalls; only the release waits for them.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    busy      = 1'b0;
    releasing = 1'b0;
    unique case (state)
      RUN: begin
        busy = start & MULTI;
        if (start && MULTI && !kill && !hold) begin
          state_nxt = BUSY;
          cnt_nxt   = LOAD;
        end
      end
      BUSY: begin
        busy      = 1'b1;
        releasing = (cnt == '0) && !hold;
        if (kill) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end else if (cnt != '0) begin
          cnt_nxt = cnt - CW'(1);
        end else if (!hold) begin
          state_nxt = RUN;
        end
      end
      default: begin
        state_nxt = RUN;
        cnt_nxt   = '0;
      end
    endcase
  end

endmodule

// File: rtl/pipe_flow_ctrl.sv
// Pipeline flow controller: hazard stalls, multi-cycle op hold, redirect/trap
// flush and a saturating stall-cycle counter. Enables/clears are combinational.
module pipe_flow_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned NUM_PREGS     = STG_WB,
  parameter int unsigned RESOLVE_STAGE = STG_MEM,
  parameter int unsigned MC_LATENCY    = 34,
  parameter int unsigned REG_AW        = 5,
  parameter int unsigned CNT_W         = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [REG_AW-1:0]    rs1_id,
  input  logic [REG_AW-1:0]    rs2_id,
  input  logic                 use_rs1_id,
  input  logic                 use_rs2_id,
  input  logic [REG_AW-1:0]    rd_exe,
  input  logic                 mem_read_exe,
  input  logic                 csr_exe,
  input  logic                 mc_start_exe,
  input  logic                 redirect_mem,
  input  logic                 trap_req,
  input  logic                 ext_stall,
  output logic                 pc_en,
  output logic [NUM_PREGS-1:0] preg_en,
  output logic [NUM_PREGS-1:0] preg_clr,
  output logic                 mc_busy,
  output logic                 trap_ack,
  output logic [CNT_W-1:0]     stall_cnt
);

  localparam logic [PREG_MAX-1:0] FLUSH_MASK = low_mask(RESOLVE_STAGE);

  flow_cmd_t cmd;
  logic      kill;
  logic      load_use;
  logic      mc_req;
  logic      mc_rel;
  logic      unused_bits;

  // A redirect or trap only takes effect when the pipe is not frozen.
  assign kill = (trap_req | redirect_mem) & ~ext_stall;

  assign load_use = (mem_read_exe | csr_exe) & (rd_exe != '0) &
                    ((use_rs1_id & (rs1_id == rd_exe)) |
                     (use_rs2_id & (rs2_id == rd_exe)));

  mc_tracker #(
    .LATENCY (MC_LATENCY)
  ) u_mc_tracker (
    .clk       (clk),
    .reset     (reset),
    .start     (mc_start_exe),
    .kill      (kill),
    .hold      (ext_stall),
    .busy      (mc_req),
    .releasing (mc_rel)
  );

  // Priority: reset > ext_stall > trap > redirect > mc stall > load-use.
  always_comb begin
    cmd.pc_en = 1'b1;
    cmd.en    = '1;
    cmd.clr   = '0;
    mc_busy   = 1'b0;
    trap_ack  = 1'b0;
    if (reset) begin
      cmd.pc_en = 1'b0;
      cmd.en    = '0;
      cmd.clr   = '1;
    end else if (ext_stall) begin
      cmd.pc_en = 1'b0;
      cmd.en    = '0;
    end else if (trap_req) begin
      cmd.clr  = FLUSH_MASK;
      trap_ack = 1'b1;
    end else if (redirect_mem) begin
      cmd.clr = FLUSH_MASK;
    end else if (mc_req && !mc_rel) begin
      cmd.pc_en        = 1'b0;
      cmd.en[STG_IF]   = 1'b0;
      cmd.en[STG_ID]   = 1'b0;
      cmd.clr[STG_EXE] = 1'b1;
      mc_busy          = 1'b1;
    end else if (load_use) begin
      cmd.pc_en       = 1'b0;
      cmd.en[STG_IF]  = 1'b0;
      cmd.clr[STG_ID] = 1'b1;
    end
  end

  assign pc_en       = cmd.pc_en;
  assign preg_en     = cmd.en[NUM_PREGS-1:0];
  assign preg_clr    = cmd.clr[NUM_PREGS-1:0];
  assign unused_bits = ^{cmd.en, cmd.clr};

  // Stall-cycle counter, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (!pc_en && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_flow_ctrl.sv
// Scoreboard bench for pipe_flow_ctrl: directed scenarios then random traffic
// against an occupancy-based reference model.
module tb_pipe_flow_ctrl;

  localparam int unsigned NP  = 4;
  localparam int unsigned RS  = 3;
  localparam int unsigned LAT = 34;
  localparam int unsigned AW  = 5;
  localparam int unsigned CW  = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic [AW-1:0] rs1_id, rs2_id, rd_exe;
  logic          use_rs1_id, use_rs2_id, mem_read_exe, csr_exe;
  logic          mc_start_exe, redirect_mem, trap_req, ext_stall;
  logic          pc_en, mc_busy, trap_ack;
  logic [NP-1:0] preg_en, preg_clr;
  logic [CW-1:0] stall_cnt;

  pipe_flow_ctrl #(
    .NUM_PREGS(NP), .RESOLVE_STAGE(RS), .MC_LATENCY(LAT), .REG_AW(AW), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset), .rs1_id(rs1_id), .rs2_id(rs2_id),
    .use_rs1_id(use_rs1_id), .use_rs2_id(use_rs2_id), .rd_exe(rd_exe),
    .mem_read_exe(mem_read_exe), .csr_exe(csr_exe), .mc_start_exe(mc_start_exe),
    .redirect_mem(redirect_mem), .trap_req(trap_req), .ext_stall(ext_stall),
    .pc_en(pc_en), .preg_en(preg_en), .preg_clr(preg_clr), .mc_busy(mc_busy),
    .trap_ack(trap_ack), .stall_cnt(stall_cnt)
  );

  typedef struct packed {
    logic          reset;
    logic [AW-1:0] rs1, rs2, rd;
    logic          u1, u2, mr, csr, start, redir, trap, ext;
  } stim_t;

  typedef struct packed {
    logic          pc_en;
    logic [NP-1:0] en;
    logic [NP-1:0] clr;
    logic          mc_busy;
    logic          ack;
    logic [CW-1:0] scnt;
  } obs_t;

  obs_t   exp_q[$];
  obs_t   mon_act, mon_exp;
  int     n_checks = 0;
  int     n_pass   = 0;
  int     cyc_no   = 0;
  int     occ      = 0;   // cycles the current multi-cycle op has spent in EXE
  longint scnt_m   = 0;

  // Reference: an op started at cycle t owns EXE for LAT cycles (stalling the
  // front end for LAT-1 of them); occupancy time keeps running under ext_stall.
  task automatic model(input stim_t s, output obs_t e);
    logic lu, mc;
    e = '0;
    e.pc_en = 1'b1;
    e.en    = '1;
    e.scnt  = CW'(scnt_m);
    lu = (s.mr || s.csr) && (s.rd != 0) &&
         ((s.u1 && s.rs1 == s.rd) || (s.u2 && s.rs2 == s.rd));
    mc = 1'b0;
    if (s.reset) begin
      e.pc_en = 1'b0; e.en = '0; e.clr = '1; occ = 0;
    end else if (s.ext) begin
      e.pc_en = 1'b0; e.en = '0;
      if (occ > 0 && occ < int'(LAT) - 1) occ++;
    end else if (s.trap || s.redir) begin
      for (int i = 0; i < int'(RS); i++) e.clr[i] = 1'b1;
      e.ack = s.trap;
      occ = 0;
    end else begin
      if (occ > 0 && occ < int'(LAT) - 1) begin mc = 1'b1; occ++; end
      else if (occ > 0) occ = 0;
      else if (s.start && LAT > 1) begin mc = 1'b1; occ = 1; end
      if (mc) begin
        e.pc_en = 1'b0; e.en = 4'b1100; e.clr = 4'b0100; e.mc_busy = 1'b1;
      end else if (lu) begin
        e.pc_en = 1'b0; e.en = 4'b1110; e.clr = 4'b0010;
      end
    end
    if (s.reset) scnt_m = 0;
    else if (!e.pc_en && scnt_m < 64'hFFFF_FFFF) scnt_m++;
  endtask

  task automatic step(input stim_t s, output obs_t e);
    @(posedge clk);
    #1;
    reset = s.reset; rs1_id = s.rs1; rs2_id = s.rs2; rd_exe = s.rd;
    use_rs1_id = s.u1; use_rs2_id = s.u2; mem_read_exe = s.mr; csr_exe = s.csr;
    mc_start_exe = s.start; redirect_mem = s.redir; trap_req = s.trap;
    ext_stall = s.ext;
    model(s, e);
    exp_q.push_back(e);
    cyc_no++;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    n_checks++;
    if (act === want) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0h want %0h", nm, cyc_no, act, want);
  endtask

  // Monitor: every presented cycle is compared with the scoreboard head.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      mon_act = {pc_en, preg_en, preg_clr, mc_busy, trap_ack, stall_cnt};
      n_checks++;
      if (mon_act === mon_exp) n_pass++;
      else $display("FAIL scoreboard cycle %0d: got pc_en=%b en=%b clr=%b busy=%b ack=%b scnt=%0d want pc_en=%b en=%b clr=%b busy=%b ack=%b scnt=%0d",
                    cyc_no, mon_act.pc_en, mon_act.en, mon_act.clr, mon_act.mc_busy,
                    mon_act.ack, mon_act.scnt, mon_exp.pc_en, mon_exp.en, mon_exp.clr,
                    mon_exp.mc_busy, mon_exp.ack, mon_exp.scnt);
    end
  end

  initial begin
    stim_t s, idle;
    obs_t  e;
    logic  trap_pending;
    idle = '0;
    reset = 1'b1; rs1_id = '0; rs2_id = '0; rd_exe = '0; use_rs1_id = 1'b0;
    use_rs2_id = 1'b0; mem_read_exe = 1'b0; csr_exe = 1'b0; mc_start_exe = 1'b0;
    redirect_mem = 1'b0; trap_req = 1'b0; ext_stall = 1'b0;
    repeat (2) @(posedge clk);

    // Reset cycle
    s = idle; s.reset = 1'b1; step(s, e); #1;
    chk("reset_pc_en", 64'(pc_en), 0);
    chk("reset_en", 64'(preg_en), 0);
    chk("reset_clr", 64'(preg_clr), 64'hF);
    s = idle; step(s, e); #1;
    chk("post_reset_scnt", 64'(stall_cnt), 0);
    chk("default_en", 64'(preg_en), 64'hF);

    // Full-latency divide
    s = idle; s.start = 1'b1;
    for (int k = 0; k < int'(LAT); k++) begin
      step(s, e); #1;
      if (k == 0) chk("div_start_clr", 64'(preg_clr), 64'h4);
      if (k == int'(LAT) - 1) begin
        chk("div_release_scnt", 64'(stall_cnt), 33);
        chk("div_release_busy", 64'(mc_busy), 0);
      end
    end
    s = idle; step(s, e);

    // ext_stall while the counter sits at zero
    s = idle; s.start = 1'b1;
    for (int k = 0; k < int'(LAT) - 1; k++) step(s, e);
    s.ext = 1'b1;
    for (int k = 0; k < 3; k++) begin step(s, e); #1; chk("ext_hold_en", 64'(preg_en), 0); end
    s.ext = 1'b0; step(s, e); #1;
    chk("ext_release_pc_en", 64'(pc_en), 1);
    s = idle; step(s, e);

    // Redirect five cycles into a divide
    s = idle; s.start = 1'b1;
    for (int k = 0; k < 5; k++) step(s, e);
    s.redir = 1'b1; step(s, e); #1;
    chk("redirect_clr", 64'(preg_clr), 64'h7);
    s = idle; step(s, e); #1;
    chk("redirect_no_busy", 64'(mc_busy), 0);
    chk("redirect_pc_en", 64'(pc_en), 1);

    // Load-use, then the same with rd=x0
    s = idle; s.mr = 1'b1; s.rd = 5'd5; s.rs1 = 5'd5; s.u1 = 1'b1;
    step(s, e); #1; chk("load_use_pc_en", 64'(pc_en), 0);
    s = idle; step(s, e); #1; chk("load_use_once", 64'(pc_en), 1);
    s = idle; s.mr = 1'b1; s.u1 = 1'b1;
    step(s, e); #1; chk("x0_no_stall", 64'(pc_en), 1);

    // Trap held through ext_stall
    s = idle; s.trap = 1'b1; s.ext = 1'b1;
    for (int k = 0; k < 2; k++) begin step(s, e); #1; chk("trap_frozen_ack", 64'(trap_ack), 0); end
    s.ext = 1'b0; step(s, e); #1;
    chk("trap_ack", 64'(trap_ack), 1);
    chk("trap_clr", 64'(preg_clr), 64'h7);
    s = idle; step(s, e); #1; chk("trap_ack_pulse", 64'(trap_ack), 0);

    // Reset in the middle of a divide, then a full restart
    s = idle; s.start = 1'b1;
    for (int k = 0; k < 10; k++) step(s, e);
    s.reset = 1'b1; step(s, e); step(s, e);
    s = idle; step(s, e); #1; chk("mid_reset_scnt", 64'(stall_cnt), 0);
    s = idle; s.start = 1'b1;
    for (int k = 0; k < int'(LAT); k++) begin
      step(s, e); #1;
      if (k == int'(LAT) - 1) chk("restart_scnt", 64'(stall_cnt), 33);
    end

    // Random traffic
    trap_pending = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      s = idle;
      s.reset = ($urandom_range(0, 499) == 0);
      s.rs1   = AW'($urandom_range(0, 3));
      s.rs2   = AW'($urandom_range(0, 3));
      s.rd    = AW'($urandom_range(0, 3));
      s.u1    = 1'($urandom_range(0, 1));
      s.u2    = 1'($urandom_range(0, 1));
      if (occ == 0) begin
        s.mr  = ($urandom_range(0, 2) == 0);
        s.csr = ($urandom_range(0, 7) == 0);
      end
      s.start = ($urandom_range(0, 9) == 0);
      s.redir = ($urandom_range(0, 79) == 0);
      s.trap  = trap_pending || ($urandom_range(0, 149) == 0);
      s.ext   = ($urandom_range(0, 5) == 0);
      step(s, e);
      trap_pending = s.trap && !e.ack && !s.reset;
    end

    @(negedge clk); #1;
    chk("queue_drained", 64'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
